// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA timing sequencer: waits for PLL lock, blanks SETTLE_FRAMES frames, then runs video.
// Define VGA_TIMING_CTRL_PATTERN_EN to replace pix_data with an internal 8-bar colour pattern.
module vga_timing_ctrl #(
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int H_VALID       = 640,
    parameter int H_FRONT       = 16,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter int V_VALID       = 480,
    parameter int V_FRONT       = 10,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic        pll_locked,
    input  logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_data_req,
    output logic        hsync,
    output logic        vsync,
    output logic [15:0] rgb,
    output logic        rgb_valid,
    output logic        frame_start,
    output logic [1:0]  ctrl_state
);
    localparam logic [9:0] H_LAST      = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
    localparam logic [9:0] V_LAST      = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
    localparam logic [9:0] HS_END      = 10'(H_SYNC);
    localparam logic [9:0] VS_END      = 10'(V_SYNC);
    localparam logic [9:0] HA          = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] HA_END      = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] VA          = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] VA_END      = 10'(V_SYNC + V_BACK + V_VALID);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_FRAMES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        lock_m, lock_s;
    logic [9:0]  h_cnt, v_cnt;
    logic [3:0]  frame_cnt;
    logic        frame_wrap;
    logic        active, run, v_win, h_act, h_req;
    logic [15:0] pix_src;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
        end
    end

    assign frame_wrap = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // Lock loss is checked first so it beats the settle-complete wrap.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOCK: if (lock_s) state_nxt = SETTLE;
            SETTLE: begin
                if (!lock_s)
                    state_nxt = WAIT_LOCK;
                else if (frame_wrap && frame_cnt == SETTLE_LAST)
                    state_nxt = RUN;
            end
            RUN:     if (!lock_s) state_nxt = WAIT_LOCK;
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) state <= WAIT_LOCK;
        else         state <= state_nxt;
    end

    // Counters stay at 0 through WAIT_LOCK so SETTLE starts on a frame boundary.
    always_ff @(posedge vga_clk) begin
        if (sys_rst || state == WAIT_LOCK || state_nxt == WAIT_LOCK) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= 10'd0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst || state != SETTLE || !lock_s)
            frame_cnt <= 4'd0;
        else if (frame_wrap)
            frame_cnt <= frame_cnt + 4'd1;
    end

    assign active = (state != WAIT_LOCK);
    assign run    = (state == RUN);
    assign v_win  = (v_cnt >= VA) && (v_cnt < VA_END);
    assign h_act  = (h_cnt >= HA) && (h_cnt < HA_END);
    assign h_req  = (h_cnt >= HA - 10'd1) && (h_cnt < HA_END - 10'd1);

    assign hsync        = !(active && h_cnt < HS_END);
    assign vsync        = !(active && v_cnt < VS_END);
    assign rgb_valid    = run && h_act && v_win;
    assign pix_data_req = run && h_req && v_win;
    assign frame_start  = run && (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign pix_x        = pix_data_req ? (h_cnt - HA + 10'd1) : 10'h3FF;
    assign pix_y        = pix_data_req ? (v_cnt - VA) : 10'h3FF;
    assign ctrl_state   = state;

`ifdef VGA_TIMING_CTRL_PATTERN_EN
    logic [9:0] x_prev;
    logic [2:0] bar;

    // x_prev lines up with the cycle the requested pixel is displayed.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) x_prev <= 10'h3FF;
        else         x_prev <= pix_x;
    end

    assign bar = 3'(x_prev / 10'd80);

    always_comb begin
        pix_src = 16'h0000;
        case (bar)
            3'd0: pix_src = 16'hFFFF;
            3'd1: pix_src = 16'hFFE0;
            3'd2: pix_src = 16'h07FF;
            3'd3: pix_src = 16'h07E0;
            3'd4: pix_src = 16'hF81F;
            3'd5: pix_src = 16'hF800;
            3'd6: pix_src = 16'h001F;
            default: pix_src = 16'h0000;
        endcase
    end
`else
    assign pix_src = pix_data;
`endif

    assign rgb = rgb_valid ? pix_src : 16'h0000;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl against a time-indexed reference model (reduced timing).
module tb_vga_timing_ctrl;
    localparam int HS = 4;
    localparam int HB = 3;
`ifdef VGA_TIMING_CTRL_PATTERN_EN
    localparam int HV = 640;
`else
    localparam int HV = 8;
`endif
    localparam int HF = 2;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VV = 2;
    localparam int VF = 1;
    localparam int SF = 2;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int FT = HT * VT;
    localparam int HA = HS + HB;
    localparam int VA = VS + VB;

    logic        vga_clk;
    logic        sys_rst;
    logic        pll_locked;
    logic [15:0] pix_data;
    logic [9:0]  pix_x, pix_y;
    logic        pix_data_req, hsync, vsync, rgb_valid, frame_start;
    logic [15:0] rgb;
    logic [1:0]  ctrl_state;
    logic [42:0] act;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cur_t;
    logic [15:0] key;
    logic [15:0] bars [8];

    vga_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF),
        .SETTLE_FRAMES(SF)
    ) dut (
        .vga_clk(vga_clk), .sys_rst(sys_rst), .pll_locked(pll_locked),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .pix_data_req(pix_data_req), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .rgb_valid(rgb_valid), .frame_start(frame_start),
        .ctrl_state(ctrl_state)
    );

    assign act = {ctrl_state, hsync, vsync, rgb_valid, pix_data_req, frame_start, pix_x, pix_y, rgb};

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Pixel source answers a request one cycle later with a registered value.
    always @(posedge vga_clk)
        pix_data <= pix_data_req ? ({pix_y[5:0], pix_x} ^ key) : 16'($urandom);

    function automatic logic [15:0] pixel(input int x, input int y);
        logic [9:0] xv, yv;
`ifdef VGA_TIMING_CTRL_PATTERN_EN
        xv = 10'(x); yv = 10'(y);
        return bars[x / 80];
`else
        xv = 10'(x); yv = 10'(y);
        return {yv[5:0], xv} ^ key;
`endif
    endfunction

    // t < 0: waiting for lock; otherwise t cycles since SETTLE was entered.
    function automatic logic [42:0] model(input int t);
        int pos, h, v;
        logic running, hs, vs, val, req, fs;
        logic [1:0] st;
        logic [9:0] px, py;
        logic [15:0] c;
        if (t < 0) return {2'd0, 1'b1, 1'b1, 3'b000, 10'h3FF, 10'h3FF, 16'h0000};
        running = (t >= SF * FT);
        st  = running ? 2'd2 : 2'd1;
        pos = t % FT;
        h   = pos % HT;
        v   = pos / HT;
        hs  = (h >= HS);
        vs  = (v >= VS);
        val = running && (h >= HA) && (h < HA + HV) && (v >= VA) && (v < VA + VV);
        req = running && (h + 1 >= HA) && (h + 1 < HA + HV) && (v >= VA) && (v < VA + VV);
        px  = req ? 10'(h + 1 - HA) : 10'h3FF;
        py  = req ? 10'(v - VA) : 10'h3FF;
        c   = val ? pixel(h - HA, v - VA) : 16'h0000;
        fs  = running && (pos == 0);
        return {st, hs, vs, val, req, fs, px, py, c};
    endfunction

    task automatic test_reset();
        sys_rst = 1'b1;
        pll_locked = 1'b1;
        repeat (5) begin
            @(negedge vga_clk);
            n_chk++;
            if (act !== model(-1)) $display("FAIL reset_outputs act=%h exp=%h", act, model(-1));
            else n_pass++;
        end
        sys_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge vga_clk);
            n_chk++;
            if (ctrl_state !== ((i == 2) ? 2'd1 : 2'd0))
                $display("FAIL lock_to_settle cycle=%0d state=%0d exp=%0d", i + 1, ctrl_state, (i == 2) ? 1 : 0);
            else n_pass++;
        end
        cur_t = 0;
    endtask

    task automatic test_settle_run();
        int valid_in_settle = 0, hs_low = 0, vs_low = 0, fs_cnt = 0;
        logic [42:0] e;
        while (cur_t < (SF + 2) * FT) begin
            e = model(cur_t);
            n_chk++;
            if (act !== e) $display("FAIL settle_run t=%0d act=%h exp=%h", cur_t, act, e);
            else n_pass++;
            if (cur_t < SF * FT && rgb_valid === 1'b1) valid_in_settle++;
            if (cur_t >= SF * FT && cur_t < (SF + 1) * FT) begin
                if (hsync === 1'b0) hs_low++;
                if (vsync === 1'b0) vs_low++;
            end
            if (cur_t >= SF * FT && frame_start === 1'b1) fs_cnt++;
            @(negedge vga_clk);
            cur_t++;
        end
        n_chk++;
        if (valid_in_settle !== 0) $display("FAIL settle_blank valid_cycles=%0d exp=0", valid_in_settle);
        else n_pass++;
        n_chk++;
        if (hs_low !== HS * VT) $display("FAIL hsync_width low=%0d exp=%0d", hs_low, HS * VT);
        else n_pass++;
        n_chk++;
        if (vs_low !== VS * HT) $display("FAIL vsync_width low=%0d exp=%0d", vs_low, VS * HT);
        else n_pass++;
        n_chk++;
        if (fs_cnt !== 2) $display("FAIL frame_start_count got=%0d exp=2", fs_cnt);
        else n_pass++;
    endtask

    task automatic relock(input string tag);
        logic [42:0] e;
        int wait_cyc;
        wait_cyc = $urandom_range(3, 20);
        repeat (wait_cyc) begin
            n_chk++;
            if (act !== model(-1)) $display("FAIL %s_wait act=%h exp=%h", tag, act, model(-1));
            else n_pass++;
            @(negedge vga_clk);
        end
        pll_locked = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge vga_clk);
            e = (i == 2) ? model(0) : model(-1);
            n_chk++;
            if (act !== e) $display("FAIL %s_relock cycle=%0d act=%h exp=%h", tag, i + 1, act, e);
            else n_pass++;
        end
        cur_t = 0;
    endtask

    task automatic test_lock_drop(input int drop_t);
        logic [42:0] e;
        while (cur_t <= drop_t) begin
            e = model(cur_t);
            n_chk++;
            if (act !== e) $display("FAIL drop_pre t=%0d act=%h exp=%h", cur_t, act, e);
            else n_pass++;
            if (cur_t == drop_t) pll_locked = 1'b0;
            @(negedge vga_clk);
            cur_t++;
        end
        repeat (2) begin
            e = model(cur_t);
            n_chk++;
            if (act !== e) $display("FAIL drop_sync t=%0d act=%h exp=%h", cur_t, act, e);
            else n_pass++;
            @(negedge vga_clk);
            cur_t++;
        end
        relock("lock_drop");
    endtask

    task automatic test_midframe_reset(input int rst_t);
        logic [42:0] e;
        while (cur_t <= rst_t) begin
            e = model(cur_t);
            n_chk++;
            if (act !== e) $display("FAIL mid_reset_pre t=%0d act=%h exp=%h", cur_t, act, e);
            else n_pass++;
            if (cur_t == rst_t) sys_rst = 1'b1;
            @(negedge vga_clk);
            cur_t++;
        end
        n_chk++;
        if (act !== model(-1)) $display("FAIL mid_reset act=%h exp=%h", act, model(-1));
        else n_pass++;
        sys_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge vga_clk);
            e = (i == 2) ? model(0) : model(-1);
            n_chk++;
            if (act !== e) $display("FAIL mid_reset_resync cycle=%0d act=%h exp=%h", i + 1, act, e);
            else n_pass++;
        end
        cur_t = 0;
    endtask

    task automatic test_back_to_back();
        logic [42:0] e;
        while (cur_t < (SF + 1) * FT) begin
            e = model(cur_t);
            n_chk++;
            if (act !== e) $display("FAIL back_to_back t=%0d act=%h exp=%h", cur_t, act, e);
            else n_pass++;
            @(negedge vga_clk);
            cur_t++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        key = 16'($urandom);
        bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
        bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;
        test_reset();
        test_settle_run();
        test_lock_drop(cur_t + $urandom_range(0, FT - 1));
        test_lock_drop(SF * FT - 3);
        test_lock_drop($urandom_range(0, SF * FT - 4));
        test_midframe_reset(SF * FT + $urandom_range(0, FT - 1));
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
